fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  - Instruction buffer between fetch (PC + instruction_mem) and decode.
//  - Captures {pc, instr} pairs from fetch and presents them in order to decode with valid/ready.
//  - Absorbs decode stalls so the PC can keep advancing.
//  - Drops all buffered entries on a redirect flush (branch/jump taken).
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  XLEN    32  width of pc and instr
// PORTS
//  clk        in   1       rising-edge clock, single clock domain
//  reset      in   1       asynchronous, active-high; clears all state
//  flush      in   1       redirect: discard all entries this cycle
//  if_valid   in   1       fetch presents a valid {if_pc, if_instr}
//  if_pc      in   XLEN    PC of the fetched instruction
//  if_instr   in   XLEN    instruction word from instruction_mem
//  if_ready   out  1       queue accepts a push this cycle
//  id_valid   out  1       head entry valid for decode
//  id_pc      out  XLEN    head entry PC
//  id_instr   out  XLEN    head entry instruction
//  id_ready   in   1       decode consumes the head this cycle
//  count      out  $clog2(DEPTH)+1   occupied entries
// BEHAVIOUR
//  - Reset values (async, immediate): wr_ptr=0, rd_ptr=0, count=0, id_valid=0, id_pc=0,
//    id_instr=NOP (32'h00000013), if_ready=1.
//  - push = if_valid & if_ready; pop = id_valid & id_ready; both evaluated per rising edge.
//  - if_ready = (count != DEPTH). Registered state only; no combinational path from id_ready.
//  - id_valid = (count != 0); id_pc/id_instr = mem[rd_ptr] when valid, else 0 / NOP.
//  - Latency: push in cycle N -> visible at head in cycle N+1.
//  - Push and pop in the same cycle: count unchanged; both pointers advance.
//  - Full: if_ready=0, so no push. A pop the same cycle frees a slot from N+1 onward.
//  - Empty: id_valid=0, so no pop.
//  - Pointers wrap modulo DEPTH (ADDR_W = $clog2(DEPTH) bits, natural overflow).
//  - count = count + push - pop, never outside 0..DEPTH.
//  - flush has priority over push and pop: next state is wr_ptr=rd_ptr=0, count=0.
//    The push offered in the flush cycle is dropped. Outputs revert to empty values in cycle N+1.
//  - reset mid-stream: all entries lost immediately; storage contents need no clearing.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined:
//    - When count==0 and if_valid, id_valid=1 with id_pc/id_instr = if_pc/if_instr in the same cycle.
//    - If id_ready is also high, the entry is consumed and not written (count stays 0).
//    - If id_ready is low, the entry is written as a normal push.
//    - flush suppresses the bypass: id_valid=0 that cycle.
//  FETCH_QUEUE_BYPASS_EN undefined:
//    - Strict 1-cycle latency; outputs depend only on registered state.
// STRUCTURE
//  - Shared package fetch_pkg:
//    - XLEN_DEFAULT=32
//    - NOP_INSTR=32'h00000013
//    - typedef fetch_entry_t {pc, instr}
//  - Sub-module fetch_queue_mem:
//    - DEPTH x (2*XLEN) register array.
//    - Synchronous write port, combinational read port at rd_ptr.
//    - No reset on storage.
//  - Top level holds pointers, count, flush/bypass logic and output muxing.
// TESTING (DEPTH=4, bypass off unless stated)
//  1. reset held, then released -> id_valid=0, id_instr=32'h00000013, if_ready=1, count=0.
//  2. Push pc 0x0,0x4,0x8,0xC with id_ready=0 -> count=4, if_ready=0.
//     A 5th push (0x10) is ignored. Drain -> pcs 0x0,0x4,0x8,0xC in order.
//  3. Hold if_valid=1 and id_ready=1 for 10 cycles, pc +4 each cycle -> count stays 1 after fill.
//     Output pc trails input by 1 cycle; pointers wrap with no loss.
//  4. count=3, then flush=1 together with if_valid (pc 0x40) -> next cycle count=0, id_valid=0.
//     0x40 is never seen at the output.
//  5. Assert reset asynchronously mid-cycle with count=2 -> id_valid=0 before the next clk edge.
//  6. FETCH_QUEUE_BYPASS_EN: empty, if_valid with pc 0x100, id_ready=1 -> id_pc=0x100 same cycle, count stays 0.
//     Repeat with id_ready=0 -> count=1 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: default datapath width, the NOP
// encoding presented on an empty head, and the {pc, instr} entry layout.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    // addi x0, x0, 0 -- a harmless instruction for decode to see when idle
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue: DEPTH words of {pc, instr}, one
// synchronous write port and one combinational read port. Storage is not
// reset; the top-level pointers and count decide what is meaningful.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the accepted entry into the slot addressed by the write pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. Holds {pc, instr} pairs in
// order, absorbs decode stalls, and drops everything on a redirect flush.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, an empty
// queue forwards the fetch word straight to decode in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_instr,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_instr,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic [2*XLEN-1:0] head_s;
    logic              mem_valid_s;
    logic              bypass_s;
    logic              wr_en_s;
    logic              mem_pop_s;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data ({if_pc, if_instr}),
        .rd_addr (rd_ptr_r),
        .rd_data (head_s)
    );

    // Decide what is written, what is consumed, and what decode sees
    always_comb begin
        mem_valid_s = (count_r != CNT_W'(0));
        if_ready    = (count_r != CNT_W'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s    = (count_r == CNT_W'(0)) && if_valid && !flush;
`else
        bypass_s    = 1'b0;
`endif
        id_valid    = mem_valid_s || bypass_s;
        // A bypassed word that decode takes immediately never lands in storage
        wr_en_s     = if_valid && if_ready && !flush && !(bypass_s && id_ready);
        mem_pop_s   = mem_valid_s && id_ready && !flush;
        if (mem_valid_s) begin
            id_pc    = head_s[2*XLEN-1:XLEN];
            id_instr = head_s[XLEN-1:0];
        end else if (bypass_s) begin
            id_pc    = if_pc;
            id_instr = if_instr;
        end else begin
            id_pc    = {XLEN{1'b0}};
            id_instr = XLEN'(NOP_INSTR);
        end
    end

    // Advance pointers and occupancy; flush empties the queue ahead of push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (mem_pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            case ({wr_en_s, mem_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH=4). Stimulus pushes the
// expected head entries into a scoreboard; a monitor pops and compares
// whenever decode consumes an entry. Directed checks cover reset, full,
// wrap, flush and asynchronous reset; bypass checks run only when
// FETCH_QUEUE_BYPASS_EN is defined.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    fetch_entry_t sb[$];

    fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .id_ready (id_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    // Drive a fetch word and, when it will be accepted, record it as expected
    task automatic offer(input logic [31:0] pc, input bit expect_it);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = mk_instr(pc);
        if (expect_it) sb.push_back('{pc: pc, instr: mk_instr(pc)});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed head must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && !flush && id_valid && id_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", id_pc, 32'hFFFFFFFF);
            end else begin
                fetch_entry_t e;
                e = sb.pop_front();
                chk("order_pc", id_pc, e.pc);
                chk("order_instr", id_instr, e.instr);
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = 32'h0;
        if_instr = 32'h0; id_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // 1. reset values
        @(negedge clk);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_instr", id_instr, NOP);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_if_ready", {31'h0, if_ready}, 32'h1);
        chk("rst_count", {29'h0, count}, 32'h0);
        tick();

        // 2. fill to full, reject a fifth push, drain in order
        for (int i = 0; i < 4; i++) begin
            offer(32'(i * 4), 1'b1);
            tick();
        end
        if_valid = 1'b0;
        @(negedge clk);
        chk("full_count", {29'h0, count}, 32'h4);
        chk("full_if_ready", {31'h0, if_ready}, 32'h0);
        tick();
        offer(32'h10, 1'b0);
        tick();
        if_valid = 1'b0;
        @(negedge clk);
        chk("full_reject_count", {29'h0, count}, 32'h4);
        tick();
        id_ready = 1'b1;
        repeat (4) tick();
        id_ready = 1'b0;
        @(negedge clk);
        chk("drain_count", {29'h0, count}, 32'h0);
        chk("drain_id_valid", {31'h0, id_valid}, 32'h0);
        tick();

        // 3. streaming push+pop with pointer wrap
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(32'h200 + 32'(i * 4), 1'b1);
            @(negedge clk);
            if (i > 0) begin
`ifdef FETCH_QUEUE_BYPASS_EN
                chk("stream_count", {29'h0, count}, 32'h0);
                chk("stream_same_cycle", id_pc, if_pc);
`else
                chk("stream_count", {29'h0, count}, 32'h1);
                chk("stream_trail", id_pc, if_pc - 32'h4);
`endif
            end
            tick();
        end
        if_valid = 1'b0;
        tick();
        id_ready = 1'b0;
        @(negedge clk);
        chk("stream_end_count", {29'h0, count}, 32'h0);
        chk("stream_sb_empty", 32'(sb.size()), 32'h0);
        tick();

        // 4. flush with a simultaneous push
        for (int i = 0; i < 3; i++) begin
            offer(32'h30 + 32'(i * 4), 1'b1);
            tick();
        end
        if_valid = 1'b0;
        @(negedge clk);
        chk("preflush_count", {29'h0, count}, 32'h3);
        tick();
        flush = 1'b1;
        offer(32'h40, 1'b0);
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_count", {29'h0, count}, 32'h0);
        chk("flush_id_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_id_instr", id_instr, NOP);
        tick();
        id_ready = 1'b1;
        repeat (3) tick();
        id_ready = 1'b0;

        // 5. asynchronous reset mid-cycle with two entries held
        offer(32'h50, 1'b1);
        tick();
        offer(32'h54, 1'b1);
        tick();
        if_valid = 1'b0;
        @(negedge clk);
        chk("prerst_count", {29'h0, count}, 32'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("async_rst_count", {29'h0, count}, 32'h0);
        sb.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_if_ready", {31'h0, if_ready}, 32'h1);
        tick();

`ifdef FETCH_QUEUE_BYPASS_EN
        // 6. bypass on an empty queue
        id_ready = 1'b1;
        offer(32'h100, 1'b1);
        @(negedge clk);
        chk("byp_id_valid", {31'h0, id_valid}, 32'h1);
        chk("byp_id_pc", id_pc, 32'h100);
        tick();
        if_valid = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        chk("byp_count", {29'h0, count}, 32'h0);
        tick();
        offer(32'h104, 1'b1);
        @(negedge clk);
        chk("byp_stall_pc", id_pc, 32'h104);
        tick();
        if_valid = 1'b0;
        @(negedge clk);
        chk("byp_stall_count", {29'h0, count}, 32'h1);
        tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        @(negedge clk);
        chk("byp_drain_count", {29'h0, count}, 32'h0);
`endif

        @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue
